// File: rtl/sync_fifo_ctrl_if.sv
// sync_fifo_ctrl_if
// Handshake and status bundle between a FIFO driver/monitor and the FIFO.
//   master : drives wr, rd, D_in; observes data and status
//   slave  : the FIFO itself; samples requests, returns D_out and status
interface sync_fifo_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
);
  logic              wr;
  logic              rd;
  logic [DATA_W-1:0] D_in;
  logic [DATA_W-1:0] D_out;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr, rd, D_in,
    input  D_out, full, empty, fifo_cnt, almost_full, almost_empty,
           overflow, underflow
  );

  modport slave (
    input  wr, rd, D_in,
    output D_out, full, empty, fifo_cnt, almost_full, almost_empty,
           overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl
// Single-clock byte FIFO with registered read data, registered status
// flags (coherent with fifo_cnt) and one-cycle overflow/underflow pulses.
// Ports:
//   clock : system clock, rising edge
//   rst   : asynchronous active-high reset
//   bus   : slave side of sync_fifo_ctrl_if (wr, rd, D_in in;
//           D_out, full, empty, fifo_cnt, almost_full, almost_empty,
//           overflow, underflow out)
module sync_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 4,
  parameter int AF_LVL = 6,
  parameter int AE_LVL = 2
) (
  input  logic            clock,
  input  logic            rst,
  sync_fifo_ctrl_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [DATA_W-1:0] dout;
  logic              full_r;
  logic              empty_r;
  logic              af_r;
  logic              ae_r;
  logic              ovf_r;
  logic              udf_r;
  logic              wr_ok;
  logic              rd_ok;

  // A write into a full FIFO is allowed when a read frees a slot on the
  // same edge; a read of an empty FIFO is never bypassed from D_in.
  always_comb begin
    wr_ok    = bus.wr & (~full_r | bus.rd);
    rd_ok    = bus.rd & ~empty_r;
    cnt_next = cnt + CNT_W'(wr_ok) - CNT_W'(rd_ok);
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_ptr] <= bus.D_in;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      dout    <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      af_r    <= 1'b0;
      ae_r    <= 1'b1;
      ovf_r   <= 1'b0;
      udf_r   <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        // Non-blocking read sees the old entry even when the same slot
        // is being overwritten by a simultaneous write on a full FIFO.
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      cnt     <= cnt_next;
      full_r  <= (cnt_next == CNT_W'(DEPTH));
      empty_r <= (cnt_next == '0);
      af_r    <= (cnt_next >= CNT_W'(AF_LVL));
      ae_r    <= (cnt_next <= CNT_W'(AE_LVL));
      ovf_r   <= bus.wr & full_r & ~bus.rd;
      udf_r   <= bus.rd & empty_r;
    end
  end

  assign bus.D_out        = dout;
  assign bus.fifo_cnt     = cnt;
  assign bus.full         = full_r;
  assign bus.empty        = empty_r;
  assign bus.almost_full  = af_r;
  assign bus.almost_empty = ae_r;
  assign bus.overflow     = ovf_r;
  assign bus.underflow    = udf_r;
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
module tb_sync_fifo_ctrl;
  localparam int DEPTH = 8;

  logic clock;
  logic rst;

  sync_fifo_ctrl_if #(.DATA_W(8), .CNT_W(4)) bus ();

  sync_fifo_ctrl #(
    .DATA_W(8), .DEPTH(DEPTH), .CNT_W(4), .AF_LVL(6), .AE_LVL(2)
  ) dut (
    .clock(clock),
    .rst  (rst),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model: occupancy is just the queue length.
  logic [7:0] mq[$];
  logic [7:0] m_dout;
  logic       m_ovf;
  logic       m_udf;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] din;
    int         cnt;
    logic [7:0] dout;
    logic [5:0] flags; // {full, empty, af, ae, ovf, udf}
  } vec_t;

  vec_t tbl[$];

  function automatic logic [5:0] flags_for(int n, logic ovf, logic udf);
    return {n == DEPTH, n == 0, n >= 6, n <= 2, ovf, udf};
  endfunction

  function automatic vec_t mkvec(logic wr, logic rd, logic [7:0] din,
                                 int cnt, logic [7:0] dout,
                                 logic ovf, logic udf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = din; v.cnt = cnt; v.dout = dout;
    v.flags = flags_for(cnt, ovf, udf);
    return v;
  endfunction

  function automatic logic [5:0] dut_flags();
    return {bus.full, bus.empty, bus.almost_full, bus.almost_empty,
            bus.overflow, bus.underflow};
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout = 8'h00;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  // Called just after a falling edge: drive, step one clock, update the
  // model from the rules, return at the following falling edge.
  task automatic apply(logic wr, logic rd, logic [7:0] din);
    int n;
    logic wr_ok, rd_ok;
    bus.wr = wr; bus.rd = rd; bus.D_in = din;
    @(posedge clock);
    n     = mq.size();
    wr_ok = wr && (n < DEPTH || rd);
    rd_ok = rd && (n > 0);
    m_ovf = wr && (n == DEPTH) && !rd;
    m_udf = rd && (n == 0);
    if (rd_ok) m_dout = mq.pop_front();
    if (wr_ok) mq.push_back(din);
    @(negedge clock);
    bus.wr = 1'b0; bus.rd = 1'b0;
  endtask

  task automatic check_model(string tag);
    check({tag, "_cnt"},   int'(bus.fifo_cnt), mq.size());
    check({tag, "_dout"},  int'(bus.D_out), int'(m_dout));
    check({tag, "_flags"}, int'(dut_flags()),
          int'(flags_for(mq.size(), m_ovf, m_udf)));
  endtask

  initial begin
    logic [7:0] b;
    // Fill / overflow / full simultaneous / drain / underflow sequence.
    for (int i = 0; i < 8; i++)
      tbl.push_back(mkvec(1, 0, 8'(8'h11 + i), i + 1, 8'h00, 0, 0));
    tbl.push_back(mkvec(1, 0, 8'hAA, 8, 8'h00, 1, 0));
    tbl.push_back(mkvec(0, 0, 8'h00, 8, 8'h00, 0, 0));
    tbl.push_back(mkvec(1, 1, 8'h55, 8, 8'h11, 0, 0));
    for (int i = 0; i < 7; i++)
      tbl.push_back(mkvec(0, 1, 8'h00, 7 - i, 8'(8'h12 + i), 0, 0));
    tbl.push_back(mkvec(0, 1, 8'h00, 0, 8'h55, 0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mkvec(0, 1, 8'h00, 0, 8'h55, 0, 1));
    tbl.push_back(mkvec(0, 0, 8'h00, 0, 8'h55, 0, 0));
    // Empty with wr & rd: write taken, read rejected, D_out holds.
    tbl.push_back(mkvec(1, 1, 8'h66, 1, 8'h55, 0, 1));
    tbl.push_back(mkvec(0, 1, 8'h00, 0, 8'h66, 0, 0));

    bus.wr = 1'b0; bus.rd = 1'b0; bus.D_in = 8'h00;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clock);
    check("reset_cnt", int'(bus.fifo_cnt), 0);
    check("reset_dout", int'(bus.D_out), 0);
    check("reset_flags", int'(dut_flags()), int'(6'b010100));
    rst = 1'b0;

    foreach (tbl[k]) begin
      apply(tbl[k].wr, tbl[k].rd, tbl[k].din);
      check($sformatf("vec%0d_cnt", k), int'(bus.fifo_cnt), tbl[k].cnt);
      check($sformatf("vec%0d_dout", k), int'(bus.D_out), int'(tbl[k].dout));
      check($sformatf("vec%0d_flags", k), int'(dut_flags()), int'(tbl[k].flags));
    end

    // Wrap-around: offset the pointers, then a full pass in order.
    for (int i = 0; i < 5; i++) apply(1, 0, 8'(8'hA0 + i));
    for (int i = 0; i < 5; i++) apply(0, 1, 8'h00);
    check_model("wrap_pre");
    for (int i = 0; i < 8; i++) apply(1, 0, 8'(8'h21 + i));
    check_model("wrap_full");
    for (int i = 0; i < 8; i++) begin
      apply(0, 1, 8'h00);
      check($sformatf("wrap_rd%0d", i), int'(bus.D_out), 8'h21 + i);
    end
    check("wrap_end_flags", int'(dut_flags()), int'(6'b010100));

    // Asynchronous reset in the middle of a write cycle.
    for (int i = 0; i < 4; i++) apply(1, 0, 8'(8'h40 + i));
    apply(0, 1, 8'h00);
    bus.wr = 1'b1; bus.D_in = 8'hEE;
    #2 rst = 1'b1;
    #1;
    check("async_rst_cnt", int'(bus.fifo_cnt), 0);
    check("async_rst_dout", int'(bus.D_out), 0);
    check("async_rst_flags", int'(dut_flags()), int'(6'b010100));
    model_reset();
    bus.wr = 1'b0;
    @(negedge clock);
    rst = 1'b0;
    apply(1, 0, 8'h77);
    check_model("post_rst_wr");
    apply(0, 1, 8'h00);
    check("post_rst_dout", int'(bus.D_out), 8'h77);
    check("post_rst_cnt", int'(bus.fifo_cnt), 0);

    // Randomized traffic: a fill-biased phase, then a drain-biased one.
    for (int i = 0; i < 600; i++) begin
      int pw;
      pw = (i < 300) ? 65 : 35;
      b = 8'($urandom_range(0, 255));
      apply($urandom_range(0, 99) < pw, $urandom_range(0, 99) < (100 - pw), b);
      check_model($sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
